// File: rtl/poly_sub_seq_if.sv
`default_nettype none
// =============================================================================
// Module      : poly_sub_seq_if
// Description : Control handshake and coefficient RAM bus for poly_sub_seq.
// Revision    : 1.0 - initial release
// =============================================================================
interface poly_sub_seq_if #(
  parameter int AW    = 8,
  parameter int WIDTH = 12
);
  logic             start;
  logic             hold;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] a_data;
  logic [WIDTH-1:0] b_data;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  // Control FSM and memory bank side.
  modport master (
    output start, hold, a_data, b_data,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  // Sequencer side.
  modport slave (
    input  start, hold, a_data, b_data,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface
`default_nettype wire

// File: rtl/poly_sub_seq.sv
`default_nettype none
// =============================================================================
// Module      : poly_sub_seq
// Description : Sequences dst[i] = (a[i] - b[i]) mod Q over N coefficients.
// Revision    : 1.0 - initial release
// =============================================================================
module poly_sub_seq #(
  parameter int N     = 256,
  parameter int AW    = 8,
  parameter int WIDTH = 12,
  parameter int Q     = 3329
) (
  input  logic          clk,
  input  logic          rst,
  poly_sub_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int               DW       = WIDTH + 2;
  localparam logic [DW-1:0]    Q_W      = DW'(Q);
  localparam logic [DW-1:0]    Q2_W     = DW'(2 * Q);
  localparam logic [AW-1:0]    LAST_IDX = AW'(N - 1);

  state_t           state_q, state_d;
  logic             s0_valid_q, s0_valid_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic             s1_valid_q, s1_valid_d;
  logic [AW-1:0]    s1_idx_q, s1_idx_d;
  logic             s2_valid_q, s2_valid_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;

  logic [DW-1:0]    diff0, diff1, diff2, diff3;
  logic [WIDTH-1:0] mod_res;

  // Adding 2Q keeps the difference non-negative; three subtractions then
  // bring even non-canonical 12-bit operands (max 10753) into [0, Q-1].
  always_comb begin
    diff0   = {2'b00, bus.a_data} - {2'b00, bus.b_data} + Q2_W;
    diff1   = (diff0 >= Q_W) ? diff0 - Q_W : diff0;
    diff2   = (diff1 >= Q_W) ? diff1 - Q_W : diff1;
    diff3   = (diff2 >= Q_W) ? diff2 - Q_W : diff2;
    mod_res = WIDTH'(diff3);
  end

  always_comb begin
    state_d    = state_q;
    s0_valid_d = s0_valid_q;
    rd_addr_d  = rd_addr_q;
    s1_valid_d = s1_valid_q;
    s1_idx_d   = s1_idx_q;
    s2_valid_d = s2_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.hold) begin
          state_d    = RUN;
          s0_valid_d = 1'b1;
          rd_addr_d  = '0;
        end
      end
      RUN: begin
        if (!bus.hold) begin
          if (rd_addr_q == LAST_IDX) begin
            s0_valid_d = 1'b0;
            state_d    = DRAIN;
          end else begin
            rd_addr_d = rd_addr_q + AW'(1);
          end
        end
      end
      DRAIN: begin
        // With S1 empty, the last result is in S2 and writes this cycle.
        if (!bus.hold && !s1_valid_q) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // S1 data is the RAM output register itself, held by the RAM while rd_en=0.
    if (!bus.hold) begin
      s1_valid_d = s0_valid_q;
      if (s0_valid_q) s1_idx_d = rd_addr_q;
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        wr_addr_d = s1_idx_q;
        wr_data_d = mod_res;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      s0_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s2_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      s0_valid_q <= s0_valid_d;
      rd_addr_q  <= rd_addr_d;
      s1_valid_q <= s1_valid_d;
      s1_idx_q   <= s1_idx_d;
      s2_valid_q <= s2_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign bus.rd_en   = s0_valid_q & ~bus.hold;
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_en   = s2_valid_q & ~bus.hold;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done    = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_poly_sub_seq.sv
`default_nettype none
// =============================================================================
// Module      : tb_poly_sub_seq
// Description : Directed, table-driven bench for poly_sub_seq.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_poly_sub_seq;
  localparam int N     = 256;
  localparam int AW    = 8;
  localparam int WIDTH = 12;
  localparam int Q     = 3329;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  poly_sub_seq_if #(.AW(AW), .WIDTH(WIDTH)) bus ();

  poly_sub_seq #(.N(N), .AW(AW), .WIDTH(WIDTH), .Q(Q)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int a;
    int b;
    int exp;
  } vec_t;

  int ram_a [N];
  int ram_b [N];
  int exp_dst [N];
  int dst [N];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int t0    = 0;
  bit mon_on = 1'b0;

  int wr_cnt, order_err, hold_viol, done_cnt, done_cyc, exp_next, rd_after_done;
  int first_wr, last_wr, first_rd, last_rd, first_busy, last_busy;

  always @(posedge clk) cyc <= cyc + 1;

  // Source RAMs: registered read, output held while rd_en is low.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.a_data <= WIDTH'(ram_a[bus.rd_addr]);
      bus.b_data <= WIDTH'(ram_b[bus.rd_addr]);
    end
  end

  always @(negedge clk) begin
    int rel;
    #1;
    if (mon_on) begin
      rel = cyc - t0;
      if (bus.hold && (bus.rd_en || bus.wr_en)) hold_viol++;
      if (done_cnt > 0 && bus.rd_en) rd_after_done++;
      if (bus.rd_en) begin
        if (first_rd < 0) first_rd = rel;
        last_rd = rel;
      end
      if (bus.busy) begin
        if (first_busy < 0) first_busy = rel;
        last_busy = rel;
      end
      if (bus.wr_en) begin
        if (first_wr < 0) first_wr = rel;
        last_wr = rel;
        if (int'(bus.wr_addr) != exp_next || exp_next >= N) order_err++;
        dst[bus.wr_addr] = int'(bus.wr_data);
        exp_next++;
        wr_cnt++;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = rel;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_busy"},    int'(bus.busy),    0);
    chk({tag, "_done"},    int'(bus.done),    0);
    chk({tag, "_rd_en"},   int'(bus.rd_en),   0);
    chk({tag, "_rd_addr"}, int'(bus.rd_addr), 0);
    chk({tag, "_wr_en"},   int'(bus.wr_en),   0);
    chk({tag, "_wr_addr"}, int'(bus.wr_addr), 0);
    chk({tag, "_wr_data"}, int'(bus.wr_data), 0);
  endtask

  function automatic int mod_sub(input int a, input int b);
    int d;
    d = (a - b) % Q;
    if (d < 0) d += Q;
    return d;
  endfunction

  task automatic clear_stats();
    wr_cnt = 0; order_err = 0; hold_viol = 0; done_cnt = 0; done_cyc = -1;
    exp_next = 0; rd_after_done = 0;
    first_wr = -1; last_wr = -1; first_rd = -1; last_rd = -1;
    first_busy = -1; last_busy = -1;
    for (int i = 0; i < N; i++) dst[i] = -1;
  endtask

  // Called at a falling edge; that cycle is cycle 0 (start sampled).
  task automatic run_op(input bit with_hold, input int s_a, input int s_b,
                        input int tail, input string tag);
    int  k, burst, bad;
    bit  finished;
    clear_stats();
    t0 = cyc;
    bus.start = 1'b1;
    bus.hold  = 1'b0;
    mon_on    = 1'b1;
    k = 0; burst = 0; finished = 1'b0;
    while (!finished && k < 3000) begin
      @(negedge clk);
      k++;
      bus.start = (k == s_a) || (k == s_b);
      if (with_hold) begin
        if (burst > 0) begin
          bus.hold = 1'b1;
          burst--;
        end else if ($urandom_range(0, 99) < 15) begin
          bus.hold = 1'b1;
          burst = $urandom_range(0, 3);
        end else begin
          bus.hold = 1'b0;
        end
      end
      if (done_cnt > 0 && k >= done_cyc + tail) finished = 1'b1;
    end
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    chk({tag, "_finished"}, int'(finished), 1);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_wr_cnt"}, wr_cnt, N);
    chk({tag, "_order_err"}, order_err, 0);
    chk({tag, "_hold_viol"}, hold_viol, 0);
    chk({tag, "_rd_after_done"}, rd_after_done, 0);
    bad = 0;
    for (int i = 0; i < N; i++) if (dst[i] != exp_dst[i]) bad++;
    chk({tag, "_dst_mismatches"}, bad, 0);
    if (!with_hold) begin
      chk({tag, "_done_cyc"},   done_cyc,   N + 3);
      chk({tag, "_first_rd"},   first_rd,   1);
      chk({tag, "_last_rd"},    last_rd,    N);
      chk({tag, "_first_wr"},   first_wr,   3);
      chk({tag, "_last_wr"},    last_wr,    N + 2);
      chk({tag, "_first_busy"}, first_busy, 1);
      chk({tag, "_last_busy"},  last_busy,  N + 2);
    end
  endtask

  initial begin
    vec_t vecs [5];
    vecs[0] = '{0,    1,    3328};
    vecs[1] = '{4095, 0,    766};
    vecs[2] = '{0,    4095, 2563};
    vecs[3] = '{1234, 1234, 0};
    vecs[4] = '{3328, 0,    3328};

    rst = 1'b1;
    bus.start  = 1'b0;
    bus.hold   = 1'b0;
    bus.a_data = '0;
    bus.b_data = '0;
    clear_stats();
    repeat (3) @(negedge clk);
    #1 chk_outs_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single-coefficient corners, same pair at every index.
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < N; i++) begin
        ram_a[i] = vecs[v].a;
        ram_b[i] = vecs[v].b;
        exp_dst[i] = vecs[v].exp;
      end
      run_op(1'b0, -1, -1, 3, $sformatf("corner%0d", v));
    end

    // Ramp a[i]=i, b[i]=2i.
    for (int i = 0; i < N; i++) begin
      ram_a[i] = i;
      ram_b[i] = 2 * i;
      exp_dst[i] = mod_sub(i, 2 * i);
    end
    run_op(1'b0, -1, -1, 3, "ramp");
    chk("ramp_dst0",   dst[0],   0);
    chk("ramp_dst1",   dst[1],   3328);
    chk("ramp_dst255", dst[255], 3074);

    run_op(1'b1, -1, -1, 3, "hold");

    // Starts during busy and during the done cycle must be dropped.
    run_op(1'b0, 50, N + 3, 3, "start_ign");

    // Asynchronous reset mid-run, then a fresh start at cycle 110.
    clear_stats();
    t0 = cyc;
    bus.start = 1'b1;
    for (int k = 1; k <= 110; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 100) begin
        rst = 1'b1;
        #1 chk_outs_zero("midrst");
      end
      if (k == 102) rst = 1'b0;
    end
    chk("midrst_no_done", done_cnt, 0);
    run_op(1'b0, -1, -1, 1, "after_rst");

    // Back-to-back: second start lands in the cycle after done.
    run_op(1'b0, -1, -1, 3, "b2b");

    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
